regset_wb_init: RTL and testbench

Write-port sequencer and read-bypass front end for the RudolV register set. It sits between the pipeline's write-back/operand-fetch logic and any RegSet variant. After every reset it clears all 64 register entries, so BRAMs without preinit hold defined values. It then forwards pipeline writes, blocks writes to entry 0, and corrects same-cycle read-during-write collisions so the pipeline always sees the newest value.

---
 rtl/regset_wb_init.sv | 159 +++++++++++++++
 tb/tb_regset_wb_init.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regset_wb_init.sv
//------------------------------------------------------------------------------
// Module   : regset_wb_init
// Brief    : Write-port sequencer and read-bypass front end for the RudolV
//            register set. Clears all entries after reset, then forwards
//            pipeline writes (entry 0 is never written) and patches
//            same-cycle read-during-write collisions on both read ports.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regset_wb_init #(
   parameter int ENTRIES = 64
) (
   input  logic        clk,
   input  logic        rstn,
   // pipeline write-back
   input  logic        wb_valid,
   input  logic [5:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        wb_grubby,
   // pipeline read addresses
   input  logic [5:0]  ra1,
   input  logic [5:0]  ra2,
   // register-set write port
   output logic        rs_we,
   output logic [5:0]  rs_wa,
   output logic [31:0] rs_wd,
   output logic        rs_wg,
   // register-set read port
   output logic [5:0]  rs_ra1,
   output logic [5:0]  rs_ra2,
   input  logic [31:0] rs_rd1,
   input  logic [31:0] rs_rd2,
   input  logic        rs_rg1,
   input  logic        rs_rg2,
   // corrected read data to pipeline
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic        rg1,
   output logic        rg2,
   output logic        ready
);

   // Counter width; a single-entry set still needs a one-bit counter.
   localparam int CW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(ENTRIES - 1);

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          hit1_q, hit1_d;
   logic          hit2_q, hit2_d;
   logic          z1_q, z1_d;
   logic          z2_q, z2_d;
   logic [31:0]   wd_q;
   logic          wg_q;

   // Read addresses go straight through; the register set registers them.
   assign rs_ra1 = ra1;
   assign rs_ra2 = ra2;

   assign ready  = (state_q == S_RUN);

   // FSM and clear-counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and write-port mux: clear sweep in INIT, pipeline in RUN.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rs_we   = 1'b0;
      rs_wa   = 6'd0;
      rs_wd   = 32'd0;
      rs_wg   = 1'b0;
      case (state_q)
         S_INIT: begin
            rs_we = 1'b1;
            rs_wa = 6'(cnt_q);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == C_LAST) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            // Entry 0 is hard-wired to zero, so never spend a write on it.
            rs_we = wb_valid & (wb_addr != 6'd0);
            rs_wa = wb_addr;
            rs_wd = wb_data;
            rs_wg = wb_grubby;
         end
         default: begin
            state_d = S_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // Collision and zero-address flags for the coming read cycle.
   always_comb begin
      hit1_d = (state_q == S_RUN) & rs_we & (ra1 == rs_wa);
      hit2_d = (state_q == S_RUN) & rs_we & (ra2 == rs_wa);
      z1_d   = (ra1 == 6'd0);
      z2_d   = (ra2 == 6'd0);
   end

   // Bypass registers capture the write that the RAM read will miss.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hit1_q <= 1'b0;
         hit2_q <= 1'b0;
         z1_q   <= 1'b0;
         z2_q   <= 1'b0;
         wd_q   <= 32'd0;
         wg_q   <= 1'b0;
      end else begin
         hit1_q <= hit1_d;
         hit2_q <= hit2_d;
         z1_q   <= z1_d;
         z2_q   <= z2_d;
         wd_q   <= rs_wd;
         wg_q   <= rs_wg;
      end
   end

   // Output mux: zero until cleared, zero for entry 0, else bypass or RAM.
   always_comb begin
      rd1 = 32'd0;
      rg1 = 1'b0;
      rd2 = 32'd0;
      rg2 = 1'b0;
      if (ready) begin
         if (!z1_q) begin
            rd1 = hit1_q ? wd_q : rs_rd1;
            rg1 = hit1_q ? wg_q : rs_rg1;
         end
         if (!z2_q) begin
            rd2 = hit2_q ? wd_q : rs_rd2;
            rg2 = hit2_q ? wg_q : rs_rg2;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_regset_wb_init.sv
//------------------------------------------------------------------------------
// Module   : tb_regset_wb_init
// Brief    : Directed self-checking bench for regset_wb_init with a simple
//            registered-read register-set model attached.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regset_wb_init;

   logic        clk;
   logic        rstn;
   logic        wb_valid;
   logic [5:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_grubby;
   logic [5:0]  ra1, ra2;
   logic        rs_we;
   logic [5:0]  rs_wa;
   logic [31:0] rs_wd;
   logic        rs_wg;
   logic [5:0]  rs_ra1, rs_ra2;
   logic [31:0] rs_rd1, rs_rd2;
   logic        rs_rg1, rs_rg2;
   logic [31:0] rd1, rd2;
   logic        rg1, rg2;
   logic        ready;

   // Backdoor corruption of entry 0 in the register-set model.
   logic        poke0;

   int n_total;
   int n_bad;

   regset_wb_init #(.ENTRIES(64)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .wb_grubby (wb_grubby),
      .ra1       (ra1),
      .ra2       (ra2),
      .rs_we     (rs_we),
      .rs_wa     (rs_wa),
      .rs_wd     (rs_wd),
      .rs_wg     (rs_wg),
      .rs_ra1    (rs_ra1),
      .rs_ra2    (rs_ra2),
      .rs_rd1    (rs_rd1),
      .rs_rd2    (rs_rd2),
      .rs_rg1    (rs_rg1),
      .rs_rg2    (rs_rg2),
      .rd1       (rd1),
      .rd2       (rd2),
      .rg1       (rg1),
      .rg2       (rg2),
      .ready     (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-set model: synchronous write, registered read of old data.
   logic [31:0] mem_d [64];
   logic        mem_g [64];
   always @(posedge clk) begin
      if (poke0) begin
         mem_d[0] <= 32'hCAFEBABE;
         mem_g[0] <= 1'b1;
      end else if (rs_we) begin
         mem_d[rs_wa] <= rs_wd;
         mem_g[rs_wa] <= rs_wg;
      end
      rs_rd1 <= mem_d[rs_ra1];
      rs_rg1 <= mem_g[rs_ra1];
      rs_rd2 <= mem_d[rs_ra2];
      rs_rg2 <= mem_g[rs_ra2];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expects rstn to have just been released between edges.
   task automatic check_clear_sweep();
      for (int k = 0; k < 64; k++) begin
         chk("init_we", {31'd0, rs_we}, 32'd1);
         chk("init_wa", {26'd0, rs_wa}, k);
         chk("init_wd", rs_wd, 32'd0);
         chk("init_wg", {31'd0, rs_wg}, 32'd0);
         chk("init_ready", {31'd0, ready}, 32'd0);
         chk("init_rd1", rd1, 32'd0);
         chk("init_rd2", rd2, 32'd0);
         tick();
      end
      chk("ready_after_64", {31'd0, ready}, 32'd1);
   endtask

   task automatic idle_inputs();
      wb_valid  = 1'b0;
      wb_addr   = 6'd0;
      wb_data   = 32'd0;
      wb_grubby = 1'b0;
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      poke0   = 1'b0;
      rstn    = 1'b0;
      ra1     = 6'd0;
      ra2     = 6'd0;
      idle_inputs();
      #1;
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_rd1", rd1, 32'd0);
      tick();
      tick();
      rstn = 1'b1;
      #1;
      check_clear_sweep();

      // Entry 0 in the RAM gets garbage; reads must still see zero.
      poke0 = 1'b1;
      tick();
      poke0 = 1'b0;

      // Same-cycle write and read of x5 goes through the bypass.
      wb_valid = 1'b1; wb_addr = 6'd5; wb_data = 32'hDEADBEEF; wb_grubby = 1'b1;
      ra1 = 6'd5; ra2 = 6'd6;
      #1;
      chk("x5_we", {31'd0, rs_we}, 32'd1);
      chk("x5_wa", {26'd0, rs_wa}, 32'd5);
      chk("rs_ra1_copy", {26'd0, rs_ra1}, 32'd5);
      chk("rs_ra2_copy", {26'd0, rs_ra2}, 32'd6);
      tick();
      idle_inputs();
      chk("x5_bypass_rd1", rd1, 32'hDEADBEEF);
      chk("x5_bypass_rg1", {31'd0, rg1}, 32'd1);
      chk("x6_rd2", rd2, 32'd0);
      chk("x6_rg2", {31'd0, rg2}, 32'd0);

      // Write x7, read it one cycle later from the RAM.
      wb_valid = 1'b1; wb_addr = 6'd7; wb_data = 32'h12345678; wb_grubby = 1'b0;
      ra1 = 6'd1; ra2 = 6'd2;
      tick();
      idle_inputs();
      ra1 = 6'd7; ra2 = 6'd7;
      tick();
      chk("x7_ram_rd1", rd1, 32'h12345678);
      chk("x7_ram_rd2", rd2, 32'h12345678);
      chk("x7_ram_rg1", {31'd0, rg1}, 32'd0);

      // Both ports collide with the same write.
      wb_valid = 1'b1; wb_addr = 6'd9; wb_data = 32'h0BADF00D; wb_grubby = 1'b1;
      ra1 = 6'd9; ra2 = 6'd9;
      tick();
      idle_inputs();
      ra1 = 6'd5; ra2 = 6'd12;
      chk("x9_both_rd1", rd1, 32'h0BADF00D);
      chk("x9_both_rd2", rd2, 32'h0BADF00D);
      chk("x9_both_rg2", {31'd0, rg2}, 32'd1);
      tick();
      chk("x5_ram_rd1", rd1, 32'hDEADBEEF);
      chk("x5_ram_rg1", {31'd0, rg1}, 32'd1);
      chk("x12_clear_rd2", rd2, 32'd0);

      // Write to entry 0 is dropped and entry 0 reads as zero.
      wb_valid = 1'b1; wb_addr = 6'd0; wb_data = 32'hFFFFFFFF; wb_grubby = 1'b1;
      ra1 = 6'd0; ra2 = 6'd0;
      #1;
      chk("x0_we", {31'd0, rs_we}, 32'd0);
      tick();
      idle_inputs();
      chk("x0_rd1", rd1, 32'd0);
      chk("x0_rd2", rd2, 32'd0);
      chk("x0_rg1", {31'd0, rg1}, 32'd0);
      chk("x0_rg2", {31'd0, rg2}, 32'd0);

      // Write x3, then reset in RUN; the clear must wipe it.
      wb_valid = 1'b1; wb_addr = 6'd3; wb_data = 32'hA5A5A5A5; wb_grubby = 1'b1;
      tick();
      idle_inputs();
      ra1 = 6'd3; ra2 = 6'd3;
      tick();
      chk("x3_before_rst", rd1, 32'hA5A5A5A5);
      rstn = 1'b0;
      #1;
      chk("run_rst_ready", {31'd0, ready}, 32'd0);
      chk("run_rst_rd1", rd1, 32'd0);
      tick();
      rstn = 1'b1;
      #1;
      check_clear_sweep();
      tick();
      chk("x3_after_clear_rd1", rd1, 32'd0);
      chk("x3_after_clear_rg1", {31'd0, rg1}, 32'd0);

      // Reset in the middle of the clear sweep restarts it from entry 0.
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      #1;
      for (int k = 0; k < 30; k++) tick();
      chk("mid_init_wa30", {26'd0, rs_wa}, 32'd30);
      rstn = 1'b0;
      #1;
      chk("mid_init_wa0", {26'd0, rs_wa}, 32'd0);
      chk("mid_init_ready", {31'd0, ready}, 32'd0);
      tick();
      rstn = 1'b1;
      #1;
      check_clear_sweep();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
